// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the register file's single write port between two requesters
// (0 = ALU result, 1 = load return). A valid/ready handshake moves the
// winning request into a one-entry stage register. The stage drives the
// register file write port for exactly one cycle. Read port A is wrapped so
// that a read of the staged index returns the staged data before the register
// file itself holds it.
//
// Configuration macro: REGFILE_ARB_ROUND_ROBIN_EN
//   defined   : round-robin between the two requesters (last winner loses ties)
//   undefined : fixed priority, requester 0 always wins when valid
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   hold                  suppresses new grants; the staged write still drains
//   req{0,1}_valid/ready  handshake for each requester
//   req{0,1}_index/data   destination register and write data
//   rf_write_*            to register_file write port
//   rd_index              read request index, passed through to rf_read_index_a
//   rf_read_data_a        from register_file read port A
//   rd_data               read result with forwarding from the stage
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [INDEX_WIDTH-1:0] req0_index,
  input  logic [DATA_WIDTH-1:0]  req0_data,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [INDEX_WIDTH-1:0] req1_index,
  input  logic [DATA_WIDTH-1:0]  req1_data,

  output logic                   rf_write_enable,
  output logic [INDEX_WIDTH-1:0] rf_write_index,
  output logic [DATA_WIDTH-1:0]  rf_write_data,

  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [INDEX_WIDTH-1:0] rf_read_index_a,
  input  logic [DATA_WIDTH-1:0]  rf_read_data_a,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  logic                   stg_valid_q;
  logic [INDEX_WIDTH-1:0] stg_index_q;
  logic [DATA_WIDTH-1:0]  stg_data_q;
  logic                   last_grant_q;  // 1 = requester 1 won most recently

  logic grant0;
  logic grant1;
  logic transfer;

  // Grants look only at the valids and the arbitration state, never at the
  // requesters' index/data. Gating with reset keeps both readies low while
  // reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && !hold) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
`else
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`endif
    end
  end

`ifndef REGFILE_ARB_ROUND_ROBIN_EN
  // last_grant is still tracked in fixed-priority builds but has no reader.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  // A ready is only raised for a valid requester, so any grant is a transfer.
  assign transfer   = grant0 || grant1;

  // The stage holds a write for exactly one cycle, so the register file side
  // never needs to push back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_valid_q  <= 1'b0;
      stg_index_q  <= '0;
      stg_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      stg_valid_q <= transfer;
      if (transfer) begin
        stg_index_q  <= grant1 ? req1_index : req0_index;
        stg_data_q   <= grant1 ? req1_data : req0_data;
        last_grant_q <= grant1;
      end
    end
  end

  assign rf_write_enable = stg_valid_q;
  assign rf_write_index  = stg_index_q;
  assign rf_write_data   = stg_data_q;

  assign rf_read_index_a = rd_index;

  // The staged value is newer than anything in the register file.
  always_comb begin
    rd_data = rf_read_data_a;
    if (stg_valid_q && (stg_index_q == rd_index)) begin
      rd_data = stg_data_q;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two requesters (ALU result and load return) with a valid/ready handshake and registered issue. It also services the register file's read port A with forwarding from the staged write. It sits between the execute/load stages and `register_file`, driving that block's `write_enable`, `write_index` and `write_data` inputs and wrapping its `read_index_a`/`read_data_a` path.

## Interface
- `DATA_WIDTH`, 16: width of register data.
- `INDEX_WIDTH`, 2: register index width (2^INDEX_WIDTH registers).

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `hold`  in  1  when high, no new grant is issued; the staged write still drains.
- `req0_valid`  in  1  requester 0 (ALU) has a write pending.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_index`  in  INDEX_WIDTH  destination register for requester 0.
- `req0_data`  in  DATA_WIDTH  write data for requester 0.
- `req1_valid`, `req1_ready`, `req1_index`, `req1_data`: same as above for requester 1 (load).
- `rf_write_enable`  out  1  to `register_file.write_enable`.
- `rf_write_index`  out  INDEX_WIDTH  to `register_file.write_index`.
- `rf_write_data`  out  DATA_WIDTH  to `register_file.write_data`.
- `rd_index`  in  INDEX_WIDTH  read request index; drives `rf_read_index_a`.
- `rf_read_index_a`  out  INDEX_WIDTH  to `register_file.read_index_a`, equal to `rd_index`.
- `rf_read_data_a`  in  DATA_WIDTH  from `register_file.read_data_a`.
- `rd_data`  out  DATA_WIDTH  forwarded read result.

## Operation
- **State:**
  - Stage register: `stg_valid`, `stg_index`, `stg_data`.
  - `last_grant`: 1 bit, the requester granted most recently.
- **Grant (combinational):**
  - With `hold` = 0, the winner among valid requesters gets `reqN_ready` = 1.
  - With both valid, the winner is the requester that is not `last_grant`.
  - With `hold` = 1, both readies are 0.
  - At most one ready is high per cycle.
  - Ready never depends on its own requester's data inputs.
- **Handshake:**
  - Transfer occurs when `valid` and `ready` are both high at a rising edge.
  - A requester holds `valid`/`index`/`data` stable until accepted.
- **Stage update each edge:**
  - On a transfer: `stg_valid` = 1, index and data load from the winner, and `last_grant` = winner.
  - With no transfer: `stg_valid` = 0.
  - The stage always empties in one cycle, so there is no backpressure from the register file side.
- **Write outputs:**
  - `rf_write_enable` = `stg_valid`.
  - `rf_write_index` = `stg_index`.
  - `rf_write_data` = `stg_data`.
- **Forwarding:**
  - `rd_data` = `stg_data` when `stg_valid` and `stg_index == rd_index`.
  - Otherwise `rd_data` = `rf_read_data_a`.
- **Same index from both requesters in one cycle:**
  - Only the winner transfers; the loser transfers on a later cycle.
  - The loser's value is therefore the final register content.

## Timing
- **Reset (asynchronous, while `reset` = 0):**
  - `stg_valid` = 0, `stg_index` = 0, `stg_data` = 0, `last_grant` = 1 (requester 0 wins first).
  - Consequently `rf_write_enable` = 0, `rf_write_index` = 0, `rf_write_data` = 0.
  - `req0_ready` = 0 and `req1_ready` = 0 during reset.
- **Reset mid-operation:** a staged, unwritten value is discarded.
- **Latency:**
  - Accepted at edge N → `rf_write_enable` high during cycle N..N+1 → register written at edge N+1.
  - A read of that index sees the new value from cycle N onward, first via forwarding and then from the register file.
- **Throughput:** one write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1.
- **`hold`:** takes effect in the same cycle; a write staged before `hold` rose still completes.

## Configuration
- `REGFILE_ARB_ROUND_ROBIN_EN`:
  - **Defined:** round-robin grant as described above.
  - **Undefined:** fixed priority; requester 0 always wins when valid and `last_grant` is ignored. Requester 1 can then starve while requester 0 stays valid.

## Test plan
- **Reset:** assert reset low for 2 cycles with both requesters valid → rf_write_enable = 0, both readies = 0, rd_data = rf_read_data_a.
- **Single write:** req0 writes index 1 = 16'h0007 → req0_ready = 1 for one cycle; the next cycle has rf_write_enable = 1, index 1, data 7; rd_index = 1 then returns 7 that cycle and every later cycle.
- **Contention:** both valid from reset, req0 writing (2, 16'hAAAA) and req1 writing (2, 16'h5555) → req0 is granted first and req1 the next cycle; final read of index 2 = 16'h5555. Without the macro, req1 is granted only after req0_valid drops.
- **Sustained load:** both requesters continuously valid for 8 cycles → grants alternate exactly 0,1,0,1,...; 8 writes issue back to back.
- **Hold:** assert `hold` while req1 is valid → req1_ready = 0 and rf_write_enable drops one cycle later; deassert → req1 is accepted the same cycle.
- **Mid-write reset:** assert reset the cycle after req0 is accepted with (3, 16'h1234) → rf_write_enable goes to 0 immediately and register 3 is not written.
